// File: rtl/pulse_rate_scheduler.sv
// pulse_rate_scheduler
// Turns a quadrature rotary encoder into a saturating 4-bit rate index and
// schedules pulses whose interval shrinks as the rate grows. A 16-bit Galois
// LFSR adds jitter to each interval.
module pulse_rate_scheduler #(
    parameter int DB_CYCLES    = 16,
    parameter int RATE_MAX     = 15,
    parameter int RATE_DEFAULT = 8,
    parameter int STEP         = 8,
    parameter int JIT_BITS     = 4,
    parameter int PULSE_WIDTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_btn,
    input  logic        enable,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [3:0]  rate,
    output logic        rate_changed,
    output logic        pulse_out,
    output logic        busy
);

    localparam int DB_W    = $clog2(DB_CYCLES + 1);
    localparam int INT_MAX = (RATE_MAX + 1) * STEP + (1 << JIT_BITS) - 1;
    localparam int CNT_MAX = (INT_MAX > PULSE_WIDTH) ? INT_MAX : PULSE_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [3:0]  RATE_DEF_V = 4'(RATE_DEFAULT);
    localparam logic [3:0]  RATE_MAX_V = 4'(RATE_MAX);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, PULSE} state_t;

    // One encoder step up or down, clamped to 0..RATE_MAX.
    function automatic logic [3:0] rate_step(input logic [3:0] cur, input logic up);
        if (up)
            return (cur >= RATE_MAX_V) ? RATE_MAX_V : cur + 4'd1;
        else
            return (cur == 4'd0) ? 4'd0 : cur - 4'd1;
    endfunction

    // Nominal interval for the rate plus the low LFSR bits as jitter.
    function automatic logic [CNT_W-1:0] calc_interval(input logic [3:0] rt,
                                                       input logic [15:0] lf);
        int base;
        int jit;
        base = (RATE_MAX + 1 - int'(rt)) * STEP;
        jit  = int'(lf & 16'((1 << JIT_BITS) - 1));
        return CNT_W'(base + jit);
    endfunction

    // Galois LFSR, shifts right, taps applied when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    logic             r_a_s1, r_a_s2, r_b_s1, r_b_s2;
    logic             r_deb_a, r_deb_b, r_deb_a_d;
    logic [DB_W-1:0]  r_db_cnt_a, r_db_cnt_b;
    logic [3:0]       r_rate;
    logic             r_rate_changed;
    logic [15:0]      r_lfsr;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_busy;

    logic             w_a_fall;
    logic [3:0]       w_rate_step;
    logic [CNT_W-1:0] w_interval;
    logic             w_advance;

    assign w_a_fall    = r_deb_a_d & ~r_deb_a;
    assign w_rate_step = rate_step(r_rate, r_deb_b);
    assign w_interval  = calc_interval(r_rate, r_lfsr);
    assign w_advance   = (r_state == WAIT) && enable && (r_cnt == '0);

    assign rate         = r_rate;
    assign rate_changed = r_rate_changed;
    assign pulse_out    = r_pulse;
    assign busy         = r_busy;

    // Two-flop synchronizers for the asynchronous encoder channels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_s1 <= 1'b1;
            r_a_s2 <= 1'b1;
            r_b_s1 <= 1'b1;
            r_b_s2 <= 1'b1;
        end else begin
            r_a_s1 <= enc_a;
            r_a_s2 <= r_a_s1;
            r_b_s1 <= enc_b;
            r_b_s2 <= r_b_s1;
        end
    end

    // Debounce channel A: accept a new level only after DB_CYCLES stable cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_a    <= 1'b1;
            r_db_cnt_a <= '0;
        end else if (r_a_s2 == r_deb_a) begin
            r_db_cnt_a <= '0;
        end else if (r_db_cnt_a == DB_W'(DB_CYCLES - 1)) begin
            r_deb_a    <= r_a_s2;
            r_db_cnt_a <= '0;
        end else begin
            r_db_cnt_a <= r_db_cnt_a + DB_W'(1);
        end
    end

    // Debounce channel B, same rule as channel A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_b    <= 1'b1;
            r_db_cnt_b <= '0;
        end else if (r_b_s2 == r_deb_b) begin
            r_db_cnt_b <= '0;
        end else if (r_db_cnt_b == DB_W'(DB_CYCLES - 1)) begin
            r_deb_b    <= r_b_s2;
            r_db_cnt_b <= '0;
        end else begin
            r_db_cnt_b <= r_db_cnt_b + DB_W'(1);
        end
    end

    // Rate index: button restores the default, otherwise A-falling edge steps by B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_a_d      <= 1'b1;
            r_rate         <= RATE_DEF_V;
            r_rate_changed <= 1'b0;
        end else begin
            r_deb_a_d      <= r_deb_a;
            r_rate_changed <= 1'b0;
            if (enc_btn) begin
                if (r_rate != RATE_DEF_V) begin
                    r_rate         <= RATE_DEF_V;
                    r_rate_changed <= 1'b1;
                end
            end else if (w_a_fall && (w_rate_step != r_rate)) begin
                r_rate         <= w_rate_step;
                r_rate_changed <= 1'b1;
            end
        end
    end

    // LFSR: a seed load wins over the per-pulse advance; a zero seed would lock up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (seed_load) begin
            r_lfsr <= (seed == 16'h0000) ? LFSR_SEED : seed;
        end else if (w_advance) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // Scheduler FSM; pulse_out trails the PULSE state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_pulse <= (r_state == PULSE);
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_cnt <= w_interval - CNT_W'(1);
                    if (enable) begin
                        r_state <= WAIT;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= PULSE;
                        r_cnt   <= CNT_W'(PULSE_WIDTH - 1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        if (enable) begin
                            r_state <= LOAD;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_rate_scheduler.sv
// Testbench for pulse_rate_scheduler: two instances (with and without jitter)
// share all inputs; pulse timing is predicted from the interval formula.
`timescale 1ns/1ps
module tb_pulse_rate_scheduler;

    localparam int          PW       = 4;
    localparam logic [15:0] RST_LFSR = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst, enc_a, enc_b, enc_btn, enable, seed_load;
    logic [15:0] seed;
    logic [3:0]  rate, rate_nj;
    logic        rc, rc_nj, po, po_nj, busy, busy_nj;

    pulse_rate_scheduler #(.DB_CYCLES(4), .JIT_BITS(4)) u_dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
        .enable(enable), .seed_load(seed_load), .seed(seed),
        .rate(rate), .rate_changed(rc), .pulse_out(po), .busy(busy)
    );

    pulse_rate_scheduler #(.DB_CYCLES(4), .JIT_BITS(0)) u_nj (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
        .enable(enable), .seed_load(seed_load), .seed(seed),
        .rate(rate_nj), .rate_changed(rc_nj), .pulse_out(po_nj), .busy(busy_nj)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int rate_m   = 8;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Edge-stamped pulse rises/falls and rate_changed statistics.
    int   rises[$], falls[$], rises_nj[$], falls_nj[$];
    int   rc_hi = 0, rc_rise = 0, rc_nj_hi = 0;
    logic po_prev = 1'b0, po_nj_prev = 1'b0, rc_prev = 1'b0;

    always @(negedge clk) begin
        if (po && !po_prev)       rises.push_back(edge_n);
        if (!po && po_prev)       falls.push_back(edge_n);
        if (po_nj && !po_nj_prev) rises_nj.push_back(edge_n);
        if (!po_nj && po_nj_prev) falls_nj.push_back(edge_n);
        if (rc)                   rc_hi <= rc_hi + 1;
        if (rc && !rc_prev)       rc_rise <= rc_rise + 1;
        if (rc_nj)                rc_nj_hi <= rc_nj_hi + 1;
        po_prev    <= po;
        po_nj_prev <= po_nj;
        rc_prev    <= rc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        logic [15:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int intv(input int r, input logic [15:0] l, input bit jit);
        return (16 - r) * 8 + (jit ? int'(l[3:0]) : 0);
    endfunction

    task automatic detent(input bit cw);
        if (cw) begin
            enc_a = 1'b0; step(8); enc_b = 1'b0; step(8);
            enc_a = 1'b1; step(8); enc_b = 1'b1; step(8);
            rate_m = (rate_m < 15) ? rate_m + 1 : 15;
        end else begin
            enc_b = 1'b0; step(8); enc_a = 1'b0; step(8);
            enc_b = 1'b1; step(8); enc_a = 1'b1; step(8);
            rate_m = (rate_m > 0) ? rate_m - 1 : 0;
        end
    endtask

    task automatic press_btn();
        enc_btn = 1'b1; step(1); enc_btn = 1'b0; step(2);
        rate_m = 8;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed = s; seed_load = 1'b1; step(1); seed_load = 1'b0; step(1);
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 400;
        while ((busy || busy_nj) && budget > 0) begin
            step(1);
            budget--;
        end
        check({tag, "_idle"}, {31'd0, busy | busy_nj}, 32'd0);
        step(3);
    endtask

    // Hold enable, expect n pulses on both instances at model-predicted edges.
    task automatic run_pulses(input string tag, input int n, input int rt, input logic [15:0] l0);
        int base, fbase, bnj, fbnj, k, budget, t, tnj;
        int e[$];
        int enj[$];
        logic [15:0] l;
        base = rises.size(); fbase = falls.size();
        bnj  = rises_nj.size(); fbnj = falls_nj.size();
        k = edge_n + 1;
        enable = 1'b1;
        l   = l0;
        t   = k + 2 + intv(rt, l, 1'b1);
        tnj = k + 2 + intv(rt, l, 1'b0);
        for (int i = 0; i < n; i++) begin
            e.push_back(t);
            enj.push_back(tnj);
            l   = lfsr_adv(l);
            t   = t + PW + 1 + intv(rt, l, 1'b1);
            tnj = tnj + PW + 1 + intv(rt, l, 1'b0);
        end
        budget = ((e[n-1] > enj[n-1]) ? e[n-1] : enj[n-1]) - edge_n + 20;
        while ((rises.size() < base + n || rises_nj.size() < bnj + n) && budget > 0) begin
            step(1);
            budget--;
        end
        enable = 1'b0;
        check({tag, "_count"},
              {31'd0, (rises.size() >= base + n) && (rises_nj.size() >= bnj + n)}, 32'd1);
        wait_idle(tag);
        for (int i = 0; i < n; i++) begin
            if (base + i < rises.size())
                check($sformatf("%s_rise%0d", tag, i), rises[base+i], e[i]);
            if (bnj + i < rises_nj.size())
                check($sformatf("%s_nj_rise%0d", tag, i), rises_nj[bnj+i], enj[i]);
            if (base + i < rises.size() && fbase + i < falls.size())
                check($sformatf("%s_width%0d", tag, i), falls[fbase+i] - rises[base+i], PW);
            if (bnj + i < rises_nj.size() && fbnj + i < falls_nj.size())
                check($sformatf("%s_nj_width%0d", tag, i), falls_nj[fbnj+i] - rises_nj[bnj+i], PW);
        end
    endtask

    initial begin
        int base, bnj, rcb, rcrb, rcnb, k, budget, nd, e0, e1, n0, n1;
        bit cw;
        logic [15:0] s, l0;

        rst = 1'b1; enc_a = 1'b1; enc_b = 1'b1; enc_btn = 1'b0;
        enable = 1'b0; seed_load = 1'b0; seed = 16'h0000;
        step(3);
        check("rst_rate", rate, 8);
        check("rst_rate_changed", rc, 0);
        check("rst_pulse_out", po, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        step(2);

        // Reset mid-pulse, then the post-reset LFSR sequence.
        detent(1'b1);
        check("t1_rate_cw", rate, rate_m);
        enable = 1'b1;
        budget = 300;
        while (!po && budget > 0) begin
            step(1);
            budget--;
        end
        check("t1_pulse_seen", po, 1);
        rst = 1'b1;
        #1;
        check("t1_rst_pulse_out", po, 0);
        check("t1_rst_busy", busy, 0);
        check("t1_rst_rate", rate, 8);
        enable = 1'b0;
        step(2);
        rst = 1'b0;
        rate_m = 8;
        step(2);
        run_pulses("t1_after_reset", 3, 8, RST_LFSR);

        // Three CW detents and a short glitch.
        rcb = rc_hi; rcrb = rc_rise; rcnb = rc_nj_hi;
        for (int i = 0; i < 3; i++) detent(1'b1);
        check("t2_rate", rate, 11);
        check("t2_strobe_cycles", rc_hi - rcb, 3);
        check("t2_strobe_rises", rc_rise - rcrb, 3);
        check("t2_nj_strobe_cycles", rc_nj_hi - rcnb, 3);
        rcb = rc_hi;
        enc_a = 1'b0; step(3); enc_a = 1'b1; step(10);
        enc_b = 1'b0; step(3); enc_b = 1'b1; step(10);
        check("t2_glitch_rate", rate, 11);
        check("t2_glitch_strobes", rc_hi - rcb, 0);

        // Saturation at both ends and button restore.
        rcb = rc_hi;
        press_btn();
        check("t3_btn_rate", rate, 8);
        check("t3_btn_strobe", rc_hi - rcb, 1);
        rcb = rc_hi;
        for (int i = 0; i < 12; i++) detent(1'b1);
        check("t3_cw_sat_rate", rate, 15);
        check("t3_cw_sat_nj_rate", rate_nj, 15);
        check("t3_cw_sat_strobes", rc_hi - rcb, 7);
        rcb = rc_hi;
        for (int i = 0; i < 20; i++) detent(1'b0);
        check("t3_ccw_sat_rate", rate, 0);
        check("t3_ccw_sat_strobes", rc_hi - rcb, 15);
        rcb = rc_hi;
        press_btn();
        check("t3_btn2_rate", rate, 8);
        check("t3_btn2_strobe", rc_hi - rcb, 1);
        rcb = rc_hi;
        press_btn();
        check("t3_btn_same_strobe", rc_hi - rcb, 0);

        // Fastest rate: first pulse and steady period.
        for (int i = 0; i < 7; i++) detent(1'b1);
        check("t4_rate", rate, 15);
        load_seed(16'h5A5A);
        run_pulses("t4", 4, 15, 16'h5A5A);

        // Seeded sequences.
        load_seed(16'h0001);
        run_pulses("t5_seed1", 8, 15, 16'h0001);
        load_seed(16'h0000);
        run_pulses("t5_seed0", 8, 15, RST_LFSR);

        // Randomized rates and seeds.
        for (int it = 0; it < 4; it++) begin
            nd = $urandom_range(0, 6);
            cw = 1'($urandom_range(0, 1));
            for (int j = 0; j < nd; j++) detent(cw);
            check($sformatf("rnd%0d_rate", it), rate, rate_m);
            s = 16'($urandom);
            if ($urandom_range(0, 3) == 0) s = 16'h0000;
            load_seed(s);
            run_pulses($sformatf("rnd%0d", it), 4, rate_m, (s == 16'h0000) ? RST_LFSR : s);
        end

        // Enable drop in WAIT.
        press_btn();
        detent(1'b1);
        detent(1'b1);
        check("t6_rate", rate, 10);
        load_seed(16'h3C3C);
        base = rises.size(); bnj = rises_nj.size();
        enable = 1'b1;
        step(4);
        check("t6a_busy_wait", busy, 1);
        enable = 1'b0;
        step(1);
        check("t6a_idle_next", busy, 0);
        check("t6a_nj_idle_next", busy_nj, 0);
        step(80);
        check("t6a_no_pulse", rises.size() - base, 0);
        check("t6a_nj_no_pulse", rises_nj.size() - bnj, 0);

        // Enable drop in the second PULSE cycle.
        base = rises.size();
        enable = 1'b1;
        budget = 300;
        while (!po && budget > 0) begin
            step(1);
            budget--;
        end
        check("t6b_pulse_seen", po, 1);
        enable = 1'b0;
        step(2);
        check("t6b_mid_po", po, 1);
        check("t6b_mid_busy", busy, 1);
        step(1);
        check("t6b_end_busy", busy, 0);
        check("t6b_end_po", po, 1);
        step(1);
        check("t6b_after_po", po, 0);
        step(80);
        check("t6b_single_pulse", rises.size() - base, 1);
        if (falls.size() > 0 && rises.size() > base)
            check("t6b_width", falls[falls.size()-1] - rises[base], PW);
        wait_idle("t6b");

        // Rate change during WAIT affects only the following interval.
        l0 = 16'h0F0F;
        load_seed(l0);
        base = rises.size(); bnj = rises_nj.size();
        k = edge_n + 1;
        enable = 1'b1;
        step(2);
        detent(1'b1);
        check("t6c_rate", rate, 11);
        e0 = k + 2 + intv(10, l0, 1'b1);
        e1 = e0 + PW + 1 + intv(11, lfsr_adv(l0), 1'b1);
        n0 = k + 2 + intv(10, l0, 1'b0);
        n1 = n0 + PW + 1 + intv(11, lfsr_adv(l0), 1'b0);
        budget = 400;
        while ((rises.size() < base + 2 || rises_nj.size() < bnj + 2) && budget > 0) begin
            step(1);
            budget--;
        end
        enable = 1'b0;
        check("t6c_count", {31'd0, (rises.size() >= base + 2) && (rises_nj.size() >= bnj + 2)}, 1);
        if (rises.size() >= base + 2) begin
            check("t6c_rise0", rises[base], e0);
            check("t6c_rise1", rises[base+1], e1);
        end
        if (rises_nj.size() >= bnj + 2) begin
            check("t6c_nj_rise0", rises_nj[bnj], n0);
            check("t6c_nj_rise1", rises_nj[bnj+1], n1);
        end
        wait_idle("t6c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
